pll_lock_sequencer: RTL
=======================

# pll_lock_sequencer

Sequences the 25.2 MHz pixel-clock PLL from the 50 MHz reference domain: drives the PLL reset, waits for lock with timeout and bounded retries, qualifies lock over a stability window, then releases the pixel-pipeline reset. Any lock loss while running withdraws ready and re-runs the sequence. Sits between board reset/control logic and the pixel-clock PLL instance; `pix_rst_n` feeds the reset synchronizer of the pixel domain.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT for lock (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 4: lock timeouts tolerated before FAIL (1..15).
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous one-cycle request to restart the sequence (refclk domain).
- `pll_locked`  in  1  PLL lock; asynchronous to `refclk`, 2-flop synchronized internally to `locked_s`.
- `pll_rst`  out  1  active-high reset to the PLL.
- `pix_rst_n`  out  1  active-low reset for pixel logic; equals `ready`.
- `ready`  out  1  PLL locked and qualified.
- `fail`  out  1  retry budget exhausted.
- `state`  out  3  current state encoding.
- `retry_count`  out  4  timeouts in current sequence.

## Operation
- States: RST=0, WAIT=1, STABLE=2, RUN=3, FAIL=4. Single counter `cnt`, width sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- RST: `pll_rst`=1. At `cnt`==RST_CYCLES-1 → WAIT, `cnt`←0.
- WAIT: `pll_rst`=0. `locked_s`=1 → STABLE, `cnt`←0. Else at `cnt`==LOCK_TIMEOUT-1: `retry_count`+1; if new value == MAX_RETRIES → FAIL, else → RST, `cnt`←0.
- STABLE: `locked_s`=0 → WAIT, `cnt`←0, no retry increment (glitchy lock restarts timeout). At `cnt`==STABLE_CYCLES-1 with `locked_s`=1 → RUN.
- RUN: `ready`=1, `pix_rst_n`=1. `locked_s`=0 → RST, `cnt`←0, `retry_count`←0.
- FAIL: `pll_rst`=1, `fail`=1; held until `restart` or `rst_n`.
- `restart`=1 has priority in every state: → RST, `cnt`←0, `retry_count`←0, `fail`←0.
- All outputs registered, decoded from next state (change on the same edge as `state`).
- Reset values: state RST, `cnt`=0, `pll_rst`=1, `pix_rst_n`=0, `ready`=0, `fail`=0, `retry_count`=0, sync flops 0.

## Timing
- `pll_rst` high for exactly RST_CYCLES cycles per attempt (after reset deassertion or `restart`).
- Synchronizer latency: 2 edges. Edge 1 = first edge sampling `pll_locked`=1.
- Lock to ready: `ready` rises on edge STABLE_CYCLES+3 if lock held throughout.
- Lock loss to withdrawal: `ready`/`pix_rst_n` fall and `pll_rst` rises on edge 3 after `pll_locked` falls.
- Lock-pulse shorter than one `refclk` period may be missed; acceptable.
- `restart` takes effect on the next edge; outputs reflect RST that edge.
- `rst_n` assertion mid-sequence forces reset values immediately (asynchronous).

## Configuration
- `PLL_SEQ_LOSS_CNT_EN` defined: adds output `loss_count` [7:0], incremented on each RUN→RST lock-loss transition, saturating at 255, cleared only by `rst_n` (not by `restart`).
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
Parameters RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3.
- Release `rst_n`, `pll_locked` rises 10 cycles later and holds -> `pll_rst` high 4 cycles, `ready` rises on edge 11 after first sample of lock, `retry_count`=0.
- `pll_locked` never asserts -> three RST/WAIT cycles, `retry_count` 1,2,3, FAIL with `fail`=1 and `pll_rst`=1; `restart` pulse -> RST, `fail`=0, `retry_count`=0.
- In STABLE, drop `pll_locked` for 2 cycles at `cnt`=5 -> back to WAIT, no retry increment; re-lock -> RUN after full 8-cycle window.
- In RUN, drop `pll_locked` -> `ready`=0, `pll_rst`=1 on edge 3; re-lock -> RUN again; with `PLL_SEQ_LOSS_CNT_EN`, `loss_count`=1.
- Assert `rst_n` low mid-STABLE -> all outputs at reset values immediately; `restart` and lock timeout on same edge -> `restart` wins, `retry_count`=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Brings up the 25.2 MHz pixel-clock PLL from the 50 MHz
//               reference domain. Pulses the PLL reset, waits for lock with
//               a timeout and a bounded number of retries, qualifies lock over
//               a stability window, then releases the pixel-pipeline reset.
//               Losing lock while running withdraws ready and re-runs the
//               whole sequence.
//
// Parameters  : RST_CYCLES     cycles pll_rst is held high per attempt (>=1)
//               LOCK_TIMEOUT   cycles allowed waiting for lock (>=2)
//               STABLE_CYCLES  consecutive locked cycles required (>=1)
//               MAX_RETRIES    lock timeouts tolerated before FAIL (1..15)
//
// Ports       : refclk       in   50 MHz reference clock (only clock)
//               rst_n        in   asynchronous active-low reset
//               restart      in   one-cycle request to restart the sequence
//               pll_locked   in   PLL lock, asynchronous to refclk
//               pll_rst      out  active-high PLL reset
//               pix_rst_n    out  active-low pixel-domain reset (== ready)
//               ready        out  PLL locked and qualified
//               fail         out  retry budget exhausted
//               state        out  current state encoding (3 bits)
//               retry_count  out  lock timeouts in the current sequence
//               loss_count   out  RUN lock-loss events, saturating at 255
//                                 (only with PLL_SEQ_LOSS_CNT_EN defined)
//
// Options     : `define PLL_SEQ_LOSS_CNT_EN to add the loss_count port.
//
// Revision    : 1.0  initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pix_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_count
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  // --------------------------------------------------------------------------
  // Counter sizing: one shared counter covers the longest of the three
  // intervals. It only ever has to hold (interval - 1).
  // --------------------------------------------------------------------------
  localparam int c_max_a   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_max_len = (c_max_a > STABLE_CYCLES) ? c_max_a : STABLE_CYCLES;
  localparam int c_cnt_w   = (c_max_len > 1) ? $clog2(c_max_len) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_zero    = '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_lock_last   = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [3:0]         c_retry_max   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [3:0]           retry_q, retry_d;
  logic [3:0]           retry_inc;
  logic                 sync1_q, sync2_q;
  logic                 locked_s;
  logic                 pll_rst_q, ready_q, fail_q;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous PLL lock indication.
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s  = sync2_q;
  assign retry_inc = retry_q + 4'd1;

  // --------------------------------------------------------------------------
  // State, counter and retry registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cnt_q   <= c_cnt_zero;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. restart overrides every state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + c_cnt_one;
    retry_d = retry_q;

    if (restart) begin
      state_d = ST_RST;
      cnt_d   = c_cnt_zero;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (cnt_q == c_rst_last) begin
            state_d = ST_WAIT;
            cnt_d   = c_cnt_zero;
          end
        end

        ST_WAIT: begin
          // Lock is checked before the timeout so a lock arriving on the
          // last allowed cycle is still accepted.
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = c_cnt_zero;
          end else if (cnt_q == c_lock_last) begin
            retry_d = retry_inc;
            state_d = (retry_inc == c_retry_max) ? ST_FAIL : ST_RST;
            cnt_d   = c_cnt_zero;
          end
        end

        ST_STABLE: begin
          // A glitchy lock drops back to WAIT with a fresh timeout; it is
          // not counted as a retry.
          if (!locked_s) begin
            state_d = ST_WAIT;
            cnt_d   = c_cnt_zero;
          end else if (cnt_q == c_stable_last) begin
            state_d = ST_RUN;
            cnt_d   = c_cnt_zero;
          end
        end

        ST_RUN: begin
          cnt_d = c_cnt_zero;
          if (!locked_s) begin
            state_d = ST_RST;
            retry_d = 4'd0;
          end
        end

        ST_FAIL: begin
          cnt_d = c_cnt_zero;
        end

        default: begin
          state_d = ST_RST;
          cnt_d   = c_cnt_zero;
          retry_d = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs decoded from the next state, so they switch on the
  // same edge as state.
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      pll_rst_q <= (state_d == ST_RST) || (state_d == ST_FAIL);
      ready_q   <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign ready       = ready_q;
  assign pix_rst_n   = ready_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign retry_count = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  // --------------------------------------------------------------------------
  // Lock-loss event counter. Counts only genuine RUN->RST lock losses (a
  // restart out of RUN is not a loss) and survives restart.
  // --------------------------------------------------------------------------
  logic [7:0] loss_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if ((state_q == ST_RUN) && !locked_s && !restart && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_count = loss_q;
`endif

endmodule
`default_nettype wire
